// File: rtl/vga_wr_arbiter.sv
// vga_wr_arbiter: shares the VGA memory write port between CPU stores and a constant-word fill engine
module vga_wr_arbiter #(
  parameter int ADDR_W = 13,
  parameter int LEN_W = 12,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_data,
  input  logic [2:0]        cpu_memop,
  output logic              cpu_stall,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [LEN_W-1:0]  fill_len,
  input  logic [31:0]       fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_datain,
  output logic [2:0]        mem_memop
);
  typedef enum logic {IDLE, FILL} state_t;
  localparam int CW = $clog2(STARVE_MAX + 2);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] base_r, fill_addr;
  logic [LEN_W-1:0] len_r, idx_r;
  logic [31:0] data_r;
  logic cpu_ok, fill_req, grant_fill, grant_cpu, last, start_idle;
  always_comb begin
    cpu_ok = cpu_we && (cpu_memop == 3'd0 || cpu_memop == 3'd2 || (cpu_memop == 3'd1 && !cpu_addr[0]));
    fill_req = state == FILL && !fill_abort;
    grant_fill = fill_req && (!cpu_ok || cnt == CW'(STARVE_MAX));
    grant_cpu = cpu_ok && !grant_fill;
    cpu_stall = cpu_ok && grant_fill;
    last = grant_fill && (idx_r + 1'b1 == len_r);
    start_idle = state == IDLE && fill_start;
    fill_addr = base_r + ADDR_W'({idx_r, 2'b00});
    state_n = state;
    if (start_idle && fill_len != '0) state_n = FILL;
    else if (state == FILL && (fill_abort || last)) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      base_r <= '0;
      len_r <= '0;
      idx_r <= '0;
      data_r <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      mem_we <= 1'b0;
      mem_waddr <= '0;
      mem_datain <= '0;
      mem_memop <= '0;
    end else begin
      state <= state_n;
      fill_busy <= state_n == FILL;
      fill_done <= (start_idle && fill_len == '0) || last;
      mem_we <= grant_cpu || grant_fill;
      if (start_idle) begin
        base_r <= {fill_base[ADDR_W-1:2], 2'b00};
        len_r <= fill_len;
        data_r <= fill_data;
        idx_r <= '0;
      end else if (grant_fill) idx_r <= idx_r + 1'b1;
      // counter only advances while the fill is actually losing to the CPU
      if (grant_fill) cnt <= '0;
      else if (fill_req && cpu_ok) cnt <= cnt + 1'b1;
      if (grant_fill) begin
        mem_waddr <= fill_addr;
        mem_datain <= data_r;
        mem_memop <= 3'd2;
      end else if (grant_cpu) begin
        mem_waddr <= cpu_addr;
        mem_datain <= cpu_data;
        mem_memop <= cpu_memop;
      end
    end
  end
endmodule

// File: doc/vga_wr_arbiter.md
Name: vga_wr_arbiter

Overview:
- Write-port controller for the VGA text/pixel memory.
- Shares the single memory write port between CPU store traffic and a hardware fill engine. The fill engine clears the screen or paints a region with a constant word.
- Sits between the CPU data bus and the VGA memory write inputs (waddr, datain, memop, we), all in the CPU write clock domain.
- The read/scanout side is untouched.

Parameters:
- ADDR_W, 13, byte address width of VGA memory (8 KiB).
- LEN_W, 12, width of fill length in words; covers up to 2048 words plus 0.
- STARVE_MAX, 2, consecutive cycles the fill engine may lose arbitration before it is forced a slot.

Ports:
- clk  in  1  write-side clock (same clock as the memory write clock)
- rst  in  1  reset, synchronous, active-high
- cpu_we  in  1  CPU write request; must be held while cpu_stall=1
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_data  in  32  CPU store data, unshifted (memory does lane shifting)
- cpu_memop  in  3  0=byte, 1=half, 2=word
- cpu_stall  out  1  combinational; CPU request not accepted this cycle
- fill_start  in  1  one-cycle pulse; start fill
- fill_abort  in  1  one-cycle pulse; cancel running fill
- fill_base  in  ADDR_W  fill start byte address; bits [1:0] ignored (forced 0)
- fill_len  in  LEN_W  number of 32-bit words to write
- fill_data  in  32  fill word
- fill_busy  out  1  registered; fill in progress
- fill_done  out  1  registered one-cycle pulse; fill completed
- mem_we  out  1  registered write enable to VGA memory
- mem_waddr  out  ADDR_W  registered byte address
- mem_datain  out  32  registered write data
- mem_memop  out  3  registered memop

Behaviour:
- Reset (rst=1 at a clk edge) clears the following, regardless of any operation in flight:
  - State goes to IDLE; starvation counter goes to 0.
  - fill_busy, fill_done, mem_we, mem_waddr, mem_datain and mem_memop all go to 0.
  - A fill in progress is abandoned with no done pulse.
- Output latency: an accepted request appears on the mem_* outputs exactly 1 cycle after acceptance. mem_we=0 in any cycle where nothing was accepted; the other mem_* outputs hold their previous values.
- CPU request validity:
  - A request is valid only if cpu_memop is 0, 1 or 2, and for memop=1 cpu_addr[0]=0 (halfword at byte offset 0 or 2).
  - An invalid cpu_we is dropped: no mem_we and no stall.
- Fill state machine:
  - IDLE: fill_start latches base (with [1:0]=0), len, data, and clears the word index.
    - len=0: stay IDLE, fill_done=1 next cycle, fill_busy stays 0.
    - len>0: go to FILL; fill_busy=1 from the next cycle.
  - FILL: each granted fill slot writes fill_data at base + 4*index (modulo 2^ADDR_W, so it wraps to 0) with memop=2, then index+1.
    - The grant of word len-1 moves the block to IDLE.
    - fill_done=1 and fill_busy=0 in the same cycle that mem_we shows that last word.
  - fill_start while in FILL is ignored.
  - fill_abort while in FILL returns to IDLE next cycle with no fill_done; writes already issued stand. fill_abort in IDLE has no effect.
  - fill_start and fill_abort in the same IDLE cycle: start wins. In the same FILL cycle: abort wins.
- Arbitration, evaluated each cycle:
  - Valid CPU request, no fill pending: CPU granted, cpu_stall=0.
  - Fill pending, no valid CPU request: fill granted; starvation counter cleared.
  - Both pending:
    - Counter < STARVE_MAX: CPU is granted and the counter increments.
    - Counter = STARVE_MAX: fill is granted, cpu_stall=1, counter cleared.
    - The next cycle the counter is 0, so the held CPU request is guaranteed to be accepted.
  - A cycle with a fill slot granted on the abort cycle does not issue a write.
- CPU writes pass cpu_addr, cpu_data and cpu_memop through unmodified.

Test Plan:
- Reset check: assert rst for 2 cycles mid-fill (base 0x100, len 8) → all outputs 0, fill_busy=0, no fill_done, and a later fill_start works normally.
- Lone fill: fill_start with base=0x003, len=4, data=0x20202020 → mem_we on 4 consecutive cycles at addresses 0x000, 0x004, 0x008, 0x00C, memop=2; fill_done coincides with 0x00C; fill_busy high for exactly 4 cycles.
- Contention: fill len=6 while cpu_we is held continuously (word writes to 0x1000, data increments on each acceptance) → pattern CPU, CPU, FILL(stall=1), CPU, CPU, FILL, … ; no CPU write lost or duplicated; all 6 fill words written.
- Wrap and length zero:
  - base=0x1FF8, len=4 → addresses 0x1FF8, 0x1FFC, 0x0000, 0x0004.
  - len=0 → fill_done pulse 1 cycle after start; no mem_we; fill_busy stays 0.
- Invalid CPU ops: memop=1 at addr 0x0005, then memop=4 → no mem_we, cpu_stall=0. memop=0 at 0x0007, data 0x41 → mem_we=1 with addr 0x0007, memop 0.
- Abort and collisions: abort after 2 fill words of len=10 → no further fill writes and no fill_done. Simultaneous start+abort in IDLE → fill begins. fill_start during FILL → ignored; the original length completes.
